// File: rtl/ps2_key_encoder.sv
// rtl/ps2_key_encoder.sv - PS/2 device-side transmitter turning key events into [E0][F0]<code> frames.
// Optional power-on BAT (0xAA) frame enabled by defining PS2_ENC_BAT_EN.
module ps2_key_encoder #(
    parameter int CLK_DIV  = 4000,
    parameter int GAP_CYC  = 8000,
    parameter int IDLE_CYC = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ev_valid,
    output logic       ev_ready,
    input  logic [8:0] ev_code,
    input  logic       ev_break,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       byte_done,
    output logic       abort
);

    localparam int MAX_AB = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
    localparam int MAXP   = (MAX_AB > IDLE_CYC) ? MAX_AB : IDLE_CYC;
    localparam int CW     = $clog2(MAXP + 1);

    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HIGH    = 3'd1,
        S_LOW     = 3'd2,
        S_GAP     = 3'd3,
        S_INHIBIT = 3'd4,
        S_BAT     = 3'd5
    } state_t;

`ifdef PS2_ENC_BAT_EN
    localparam state_t      RST_STATE = S_BAT;
    localparam logic [31:0] RST_SEQ   = 32'h0000_00AA;
`else
    localparam state_t      RST_STATE = S_IDLE;
    localparam logic [31:0] RST_SEQ   = 32'h0000_0000;
`endif

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [3:0]           bit_idx, bit_n;
    logic [1:0]           byte_idx, byte_n;
    logic [1:0]           last_idx, last_n;
    logic [3:0][7:0]      seq, seq_n;
    logic [1:0]           seq_k;
    logic                 done_n, abort_n;
    logic                 nxt_bit;
    logic                 clk_oe_n, data_oe_n;

    // Frame layout: start 0, data LSB first, odd parity, stop 1.
    function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
        case (idx)
            4'd0:    return 1'b0;
            4'd9:    return ~^b;
            4'd10:   return 1'b1;
            default: return b[3'(idx - 4'd1)];
        endcase
    endfunction

    assign ev_ready = ~rst && (state == S_IDLE) && ps2_clk_i && ps2_data_i;
    assign busy     = (state != S_IDLE);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        byte_n  = byte_idx;
        last_n  = last_idx;
        seq_n   = seq;
        seq_k   = 2'd0;
        done_n  = 1'b0;
        abort_n = 1'b0;
        case (state)
            S_IDLE: begin
                if (ev_valid && ev_ready) begin
                    seq_n = '0;
                    if (ev_code[8]) begin
                        seq_n[seq_k] = 8'hE0;
                        seq_k        = seq_k + 2'd1;
                    end
                    if (ev_break) begin
                        seq_n[seq_k] = 8'hF0;
                        seq_k        = seq_k + 2'd1;
                    end
                    seq_n[seq_k] = ev_code[7:0];
                    last_n       = seq_k;
                    state_n      = S_HIGH;
                    cnt_n        = '0;
                    bit_n        = 4'd0;
                    byte_n       = 2'd0;
                end
            end
            S_HIGH: begin
                if (cnt == HALF_LAST) begin
                    cnt_n = '0;
                    // The stop bit is not guarded: once it is on the wire the byte counts as sent.
                    if (bit_idx != 4'd10 && !ps2_clk_i) begin
                        state_n = S_INHIBIT;
                        abort_n = 1'b1;
                    end else begin
                        state_n = S_LOW;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_LOW: begin
                if (cnt == HALF_LAST) begin
                    cnt_n = '0;
                    if (bit_idx == 4'd10) begin
                        state_n = S_GAP;
                        done_n  = 1'b1;
                    end else begin
                        state_n = S_HIGH;
                        bit_n   = bit_idx + 4'd1;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_n = '0;
                    if (byte_idx == last_idx) begin
                        state_n = S_IDLE;
                    end else begin
                        state_n = S_HIGH;
                        bit_n   = 4'd0;
                        byte_n  = byte_idx + 2'd1;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_INHIBIT: begin
                if (!ps2_clk_i) begin
                    cnt_n = '0;
                end else if (cnt == IDLE_LAST) begin
                    // Host released the bus long enough: replay the whole sequence.
                    state_n = S_HIGH;
                    cnt_n   = '0;
                    bit_n   = 4'd0;
                    byte_n  = 2'd0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_BAT: begin
                if (cnt == GAP_LAST) begin
                    state_n = S_HIGH;
                    cnt_n   = '0;
                    bit_n   = 4'd0;
                    byte_n  = 2'd0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase

        nxt_bit   = frame_bit(seq_n[byte_n], bit_n);
        clk_oe_n  = (state_n == S_LOW);
        data_oe_n = ((state_n == S_HIGH) || (state_n == S_LOW)) && !nxt_bit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RST_STATE;
            cnt         <= '0;
            bit_idx     <= 4'd0;
            byte_idx    <= 2'd0;
            last_idx    <= 2'd0;
            seq         <= RST_SEQ;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            byte_done   <= 1'b0;
            abort       <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            bit_idx     <= bit_n;
            byte_idx    <= byte_n;
            last_idx    <= last_n;
            seq         <= seq_n;
            ps2_clk_oe  <= clk_oe_n;
            ps2_data_oe <= data_oe_n;
            byte_done   <= done_n;
            abort       <= abort_n;
        end
    end

endmodule

// File: tb/tb_ps2_key_encoder.sv
// tb/tb_ps2_key_encoder.sv - directed bench for ps2_key_encoder with an open-drain line model.
module tb_ps2_key_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ev_valid = 1'b0;
    logic       ev_ready;
    logic [8:0] ev_code = 9'h000;
    logic       ev_break = 1'b0;
    logic       ps2_clk_oe, ps2_data_oe, busy, byte_done, abort;
    logic       host_clk_low = 1'b0;
    logic       host_data_low = 1'b0;
    wire        clk_line  = ~ps2_clk_oe & ~host_clk_low;
    wire        data_line = ~ps2_data_oe & ~host_data_low;

    int n_cmp = 0;
    int n_bad = 0;

    // Received-frame monitor (host side, samples data on the falling clock edge)
    logic [10:0] shreg = '0;
    logic [10:0] frames[$];
    int nbits = 0, fall_cnt = 0, done_cnt = 0, abort_cnt = 0;
    int rel_cnt = 0, min_gap = 1000;
    bit gap_armed = 0;

    localparam logic [10:0] FR_1C = 11'h438;
    localparam logic [10:0] FR_E0 = 11'h5C0;
    localparam logic [10:0] FR_F0 = 11'h7E0;
    localparam logic [10:0] FR_75 = 11'h4EA;
    localparam logic [10:0] FR_AA = 11'h754;

    ps2_key_encoder #(.CLK_DIV(4), .GAP_CYC(8), .IDLE_CYC(6)) dut (
        .clk(clk), .rst(rst), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_code(ev_code), .ev_break(ev_break), .ps2_clk_i(clk_line), .ps2_data_i(data_line),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .busy(busy),
        .byte_done(byte_done), .abort(abort)
    );

    always #5 clk = ~clk;

    always @(negedge clk_line) begin
        if (!host_clk_low && !rst) begin
            shreg[nbits] = data_line;
            nbits++;
            fall_cnt++;
            if (nbits == 11) begin
                frames.push_back(shreg);
                nbits = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (byte_done) done_cnt++;
        if (abort) abort_cnt++;
        if (ps2_clk_oe || ps2_data_oe) begin
            if (gap_armed && rel_cnt < min_gap) min_gap = rel_cnt;
            gap_armed = 0;
            rel_cnt = 0;
        end else begin
            rel_cnt++;
        end
        if (byte_done) gap_armed = 1;
    end

    task automatic clear_mon();
        nbits = 0; frames.delete(); fall_cnt = 0; done_cnt = 0; abort_cnt = 0;
        min_gap = 1000; gap_armed = 0;
    endtask

    task automatic send_event(input logic [8:0] c, input logic b, output bit ok);
        ok = 0;
        @(negedge clk);
        ev_valid = 1'b1; ev_code = c; ev_break = b;
        for (int i = 0; i < 200; i++) begin
            if (ev_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        @(posedge clk);
        #1 ev_valid = 1'b0;
    endtask

    task automatic wait_not_busy(input int lim, output bit ok);
        ok = 0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        bit ok;
        @(negedge clk); @(negedge clk);
        n_cmp++; if ({ev_ready, ps2_clk_oe, ps2_data_oe, busy, byte_done, abort} !== 6'b0) begin
            n_bad++; $display("FAIL reset_outputs got %b want 000000",
                {ev_ready, ps2_clk_oe, ps2_data_oe, busy, byte_done, abort});
        end
        rst = 1'b0;
        clear_mon();
`ifdef PS2_ENC_BAT_EN
        @(negedge clk);
        n_cmp++; if (ev_ready !== 1'b0 || busy !== 1'b1) begin
            n_bad++; $display("FAIL bat_busy ready=%b busy=%b want 0 1", ev_ready, busy);
        end
        wait_not_busy(400, ok);
        n_cmp++; if (!ok || frames.size() != 1 || frames[0] !== FR_AA) begin
            n_bad++; $display("FAIL bat_frame ok=%0d n=%0d want one frame %h", ok, frames.size(), FR_AA);
        end
        clear_mon();
`endif
        @(negedge clk);
        n_cmp++; if (ev_ready !== 1'b1) begin
            n_bad++; $display("FAIL idle_ready got %b want 1", ev_ready);
        end
    endtask

    task automatic test_press();
        bit ok;
        clear_mon();
        send_event(9'h01C, 1'b0, ok);
        n_cmp++; if (!ok || busy !== 1'b1 || ev_ready !== 1'b0) begin
            n_bad++; $display("FAIL press_accept ok=%0d busy=%b ready=%b want 1 1 0", ok, busy, ev_ready);
        end
        wait_not_busy(400, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL press_timeout busy still %b", busy); end
        n_cmp++; if (frames.size() != 1 || frames[0] !== FR_1C) begin
            n_bad++; $display("FAIL press_frame n=%0d first=%h want 1 %h", frames.size(),
                (frames.size() > 0) ? frames[0] : 11'h0, FR_1C);
        end
        n_cmp++; if (fall_cnt != 11 || done_cnt != 1 || abort_cnt != 0) begin
            n_bad++; $display("FAIL press_counts falls=%0d done=%0d abort=%0d want 11 1 0",
                fall_cnt, done_cnt, abort_cnt);
        end
    endtask

    task automatic test_ext_release();
        bit ok;
        clear_mon();
        send_event(9'h175, 1'b1, ok);
        wait_not_busy(1000, ok);
        n_cmp++; if (!ok || frames.size() != 3) begin
            n_bad++; $display("FAIL ext_count ok=%0d frames=%0d want 3", ok, frames.size());
        end else begin
            n_cmp++; if (frames[0] !== FR_E0 || frames[1] !== FR_F0 || frames[2] !== FR_75) begin
                n_bad++; $display("FAIL ext_bytes got %h %h %h want %h %h %h",
                    frames[0], frames[1], frames[2], FR_E0, FR_F0, FR_75);
            end
        end
        n_cmp++; if (done_cnt != 3 || min_gap < 8) begin
            n_bad++; $display("FAIL ext_gap done=%0d min_gap=%0d want 3 >=8", done_cnt, min_gap);
        end
    endtask

    task automatic test_inhibit();
        bit ok;
        bit hit;
        int k;
        clear_mon();
        send_event(9'h175, 1'b1, ok);
        hit = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (frames.size() == 1 && nbits == 4 && !ps2_clk_oe) begin hit = 1; break; end
        end
        n_cmp++; if (!hit) begin n_bad++; $display("FAIL inhibit_reach bit4 not reached frames=%0d", frames.size()); end
        host_clk_low = 1'b1;
        repeat (20) @(negedge clk);
        n_cmp++; if (abort_cnt != 1 || ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || busy !== 1'b1) begin
            n_bad++; $display("FAIL inhibit_abort aborts=%0d clk_oe=%b data_oe=%b busy=%b want 1 0 0 1",
                abort_cnt, ps2_clk_oe, ps2_data_oe, busy);
        end
        nbits = 0; frames.delete(); done_cnt = 0;
        host_clk_low = 1'b0;
        k = 0;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (ps2_data_oe) begin k = i; break; end
        end
        n_cmp++; if (k != 6) begin n_bad++; $display("FAIL inhibit_restart cycles=%0d want 6", k); end
        wait_not_busy(1000, ok);
        n_cmp++; if (!ok || frames.size() != 3 || done_cnt != 3) begin
            n_bad++; $display("FAIL inhibit_resend ok=%0d frames=%0d done=%0d want 3 3", ok, frames.size(), done_cnt);
        end else begin
            n_cmp++; if (frames[0] !== FR_E0 || frames[1] !== FR_F0 || frames[2] !== FR_75) begin
                n_bad++; $display("FAIL inhibit_bytes got %h %h %h", frames[0], frames[1], frames[2]);
            end
        end
    endtask

    task automatic test_idle_inhibit();
        bit ok;
        bit bad;
        clear_mon();
        host_clk_low = 1'b1;
        @(negedge clk);
        ev_valid = 1'b1; ev_code = 9'h01C; ev_break = 1'b0;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (ev_ready || ps2_clk_oe || ps2_data_oe || busy) bad = 1;
        end
        n_cmp++; if (bad) begin n_bad++; $display("FAIL idle_inhibit_ready ready=%b busy=%b want 0 0", ev_ready, busy); end
        host_clk_low = 1'b0;
        host_data_low = 1'b1;
        @(negedge clk);
        n_cmp++; if (ev_ready !== 1'b0) begin n_bad++; $display("FAIL rts_ready got %b want 0", ev_ready); end
        host_data_low = 1'b0;
        #1;
        n_cmp++; if (ev_ready !== 1'b1) begin n_bad++; $display("FAIL release_ready got %b want 1", ev_ready); end
        @(posedge clk);
        #1 ev_valid = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL release_accept busy=%b want 1", busy); end
        wait_not_busy(400, ok);
        n_cmp++; if (!ok || frames.size() != 1 || frames[0] !== FR_1C) begin
            n_bad++; $display("FAIL release_frame ok=%0d n=%0d want one %h", ok, frames.size(), FR_1C);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit hit;
        clear_mon();
        send_event(9'h01C, 1'b0, ok);
        hit = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (nbits == 6 && !ps2_clk_oe) begin hit = 1; break; end
        end
        n_cmp++; if (!hit || ps2_data_oe !== 1'b1) begin
            n_bad++; $display("FAIL mid_reach hit=%0d data_oe=%b want 1 1", hit, ps2_data_oe);
        end
        rst = 1'b1;
        #1;
        n_cmp++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL mid_reset clk_oe=%b data_oe=%b busy=%b want 0 0 0", ps2_clk_oe, ps2_data_oe, busy);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        clear_mon();
`ifdef PS2_ENC_BAT_EN
        wait_not_busy(400, ok);
        clear_mon();
`endif
        send_event(9'h175, 1'b0, ok);
        wait_not_busy(1000, ok);
        n_cmp++; if (!ok || frames.size() != 2) begin
            n_bad++; $display("FAIL post_reset_count ok=%0d frames=%0d want 2", ok, frames.size());
        end else begin
            n_cmp++; if (frames[0] !== FR_E0 || frames[1] !== FR_75) begin
                n_bad++; $display("FAIL post_reset_bytes got %h %h want %h %h", frames[0], frames[1], FR_E0, FR_75);
            end
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_ext_release();
        test_inhibit();
        test_idle_inhibit();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
